// File: rtl/div_iter_pkg.sv
// Shared constants and state codes for the iterative divider.
package div_iter_pkg;

  localparam int DATA_W = 32;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_BUSY = 2'b10,
    DIV_DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, subtract.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         dvd_msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] trial;
  logic [W:0] diff;

  // Compare on W+1 bits: the shifted remainder can exceed W bits.
  assign trial = {rem, dvd_msb};
  assign diff  = trial - {1'b0, divisor};
  assign q_bit = trial >= {1'b0, divisor};

  assign rem_next = q_bit ? diff[W-1:0] : trial[W-1:0];

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider answering the EX-stage start/ready handshake.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int DATA_W = div_iter_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_div_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  input  logic              start_i,
  input  logic              annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic              ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  div_state_e state;
  div_state_e state_nxt;

  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dsr;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W-1:0] q_raw;
  logic [DATA_W-1:0] q_fin;
  logic [DATA_W-1:0] r_fin;
  logic [CNT_W-1:0]  cnt;
  logic              q_bit;
  logic              neg_q;
  logic              neg_r;
  logic              s1;
  logic              s2;
  logic              accept;
  logic              last;

  assign s1   = signed_div_i & opdata1_i[DATA_W-1];
  assign s2   = signed_div_i & opdata2_i[DATA_W-1];
  assign abs1 = s1 ? -opdata1_i : opdata1_i;
  assign abs2 = s2 ? -opdata2_i : opdata2_i;

  assign accept = (state == DIV_IDLE) && (start_i == DIV_START)
                  && !annul_i;
  assign last   = cnt == CNT_W'(DATA_W - 1);

  div_step #(
    .W(DATA_W)
  ) u_step (
    .rem     (rem),
    .dvd_msb (dvd[DATA_W-1]),
    .divisor (dsr),
    .rem_next(rem_next),
    .q_bit   (q_bit)
  );

  // The dividend register doubles as the quotient accumulator.
  assign q_raw = {dvd[DATA_W-2:0], q_bit};
  assign q_fin = neg_q ? -q_raw : q_raw;
  assign r_fin = neg_r ? -rem_next : rem_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      DIV_IDLE: begin
        if (accept)
          state_nxt = (opdata2_i == '0) ? DIV_ZERO : DIV_BUSY;
      end
      DIV_ZERO: begin
        state_nxt = annul_i ? DIV_IDLE : DIV_DONE;
      end
      DIV_BUSY: begin
        if (annul_i)   state_nxt = DIV_IDLE;
        else if (last) state_nxt = DIV_DONE;
      end
      DIV_DONE: begin
        if (start_i == DIV_STOP) state_nxt = DIV_IDLE;
      end
      default: state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (accept) begin
            dvd   <= abs1;
            dsr   <= abs2;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= s1 ^ s2;
            neg_r <= s1;
          end
        end
        DIV_ZERO: begin
          if (!annul_i) begin
            result_o <= '0;
            ready_o  <= DIV_RESULT_READY;
          end
        end
        DIV_BUSY: begin
          if (!annul_i) begin
            rem <= rem_next;
            dvd <= q_raw;
            cnt <= cnt + 1'b1;
            if (last) begin
              result_o <= {r_fin, q_fin};
              ready_o  <= DIV_RESULT_READY;
            end
          end
        end
        DIV_DONE: begin
          if (start_i == DIV_STOP) begin
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter with a cycle-level reference model.
module tb_div_iter;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          signed_div;
  logic [W-1:0]  op1;
  logic [W-1:0]  op2;
  logic          start;
  logic          annul;
  logic [2*W-1:0] result;
  logic          ready;

  int checks;
  int errors;

  div_iter #(
    .DATA_W(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div),
    .opdata1_i   (op1),
    .opdata2_i   (op2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result),
    .ready_o     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_div(bit sg, logic [W-1:0] a,
                                          logic [W-1:0] b);
    longint x;
    longint y;
    longint q;
    longint r;
    if (b == '0) return 64'h0;
    x = sg ? longint'($signed(a)) : longint'({32'h0, a});
    y = sg ? longint'($signed(b)) : longint'({32'h0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction-level model: idle / waiting / holding a result.
  int          m_phase;
  int          m_left;
  logic        m_ready;
  logic [63:0] m_res;
  logic [63:0] m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_left  = 0;
      m_ready = 1'b0;
      m_res   = 64'h0;
    end else begin
      case (m_phase)
        0: if (start && !annul) begin
          m_pend  = ref_div(signed_div, op1, op2);
          m_left  = (op2 == '0) ? 1 : W;
          m_phase = 1;
        end
        1: if (annul) m_phase = 0;
           else begin
             m_left--;
             if (m_left == 0) begin
               m_phase = 2;
               m_ready = 1'b1;
               m_res   = m_pend;
             end
           end
        default: if (!start) begin
          m_phase = 0;
          m_ready = 1'b0;
          m_res   = 64'h0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("cyc_ready", {63'h0, ready}, {63'h0, m_ready});
    check("cyc_result", result, m_res);
  end

  task automatic run(bit sg, logic [W-1:0] a, logic [W-1:0] b,
                     logic [63:0] exp, int lat, int hold);
    int n;
    bit got;
    @(negedge clk);
    signed_div = sg;
    op1 = a;
    op2 = b;
    start = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < lat + 5) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) begin
        op1 = $urandom;
        op2 = $urandom;
        signed_div = ~sg;
      end
      got = ready;
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL timeout: no ready after %0d edges", n);
    end
    check("latency", 64'(n), 64'(lat));
    check("result", result, exp);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("hold_ready", {63'h0, ready}, 64'h1);
      check("hold_result", result, exp);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("drop_ready", {63'h0, ready}, 64'h0);
    check("drop_result", result, 64'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    signed_div = 1'b0;
    op1 = '0;
    op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {63'h0, ready}, 64'h0);
    check("reset_result", result, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    check("model_pin1", ref_div(1, 32'hFFFFFFF9, 32'd2),
          {32'hFFFFFFFF, 32'hFFFFFFFD});
    check("model_pin2", ref_div(1, 32'h80000000, 32'hFFFFFFFF),
          {32'h0, 32'h80000000});

    run(0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 3);
    run(1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0);
    run(1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33, 0);
    run(1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33, 0);
    run(0, 32'd5, 32'd0, 64'h0, 2, 1);
    run(1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 33, 0);
    run(0, 32'h12345678, 32'h100, {32'h78, 32'h123456}, 33, 0);
    run(0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 33, 0);

    // Flush at step 10.
    @(negedge clk);
    signed_div = 1'b0;
    op1 = 32'd1000;
    op2 = 32'd3;
    start = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    repeat (40) @(negedge clk);
    check("annul_ready", {63'h0, ready}, 64'h0);
    check("annul_result", result, 64'h0);

    run(0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 33, 0);

    // Async reset mid-divide.
    @(negedge clk);
    op1 = 32'd77;
    op2 = 32'd5;
    start = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    start = 1'b0;
    #1;
    check("arst_busy_ready", {63'h0, ready}, 64'h0);
    check("arst_busy_result", result, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset while a result is held.
    @(negedge clk);
    op1 = 32'd9;
    op2 = 32'd4;
    start = 1'b1;
    repeat (34) @(posedge clk);
    #1;
    check("pre_rst_result", result, {32'd1, 32'd2});
    #1;
    rst = 1'b1;
    start = 1'b0;
    #1;
    check("arst_done_ready", {63'h0, ready}, 64'h0);
    check("arst_done_result", result, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
